// File: rtl/systolic_collect_pkg.sv
// rtl/systolic_collect_pkg.sv - shared types and defaults for the systolic result collector
package systolic_collect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } collect_state_t;

  localparam int DEFAULT_N             = 8;
  localparam int DEFAULT_SLOT_CYCLES   = 30;
  localparam int DEFAULT_LATENCY_SLOTS = 2;
  localparam int DEFAULT_IW            = $clog2(DEFAULT_N);

  typedef struct packed {
    logic [31:0]           data;
    logic [DEFAULT_IW-1:0] index;
  } result_t;

endpackage

// File: rtl/systolic_result_fifo.sv
// rtl/systolic_result_fifo.sv - synchronous result FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module systolic_result_fifo
  import systolic_collect_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // When full, the slot being written is the one being read out this same edge.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - slot timing, yout capture and tagged result stream; SYSTOLIC_COLLECT_DISCARD_FILL_EN drops FILL captures
module systolic_result_collector
  import systolic_collect_pkg::*;
#(
  parameter  int N             = DEFAULT_N,
  parameter  int SLOT_CYCLES   = DEFAULT_SLOT_CYCLES,
  parameter  int LATENCY_SLOTS = DEFAULT_LATENCY_SLOTS,
  parameter  int DEPTH         = 4,
  parameter  int DW            = 16,
  localparam int IW            = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk30x,
  input  logic          rst,
  input  logic          enable,
  input  logic [DW-1:0] yout,
  output logic [31:0]   timing,
  output logic          capture,
  output logic [31:0]   res_data,
  output logic [IW-1:0] res_index,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          frame_done,
  output logic          overflow
);

  localparam int EW = 32 + IW;

  collect_state_t state;
  logic [IW-1:0]  slot;
  logic [IW-1:0]  slot_next;
  logic [IW-1:0]  tag;
  logic [7:0]     fill_cnt;
  logic           boundary;
  logic           push_req;
  logic           push_ok;
  logic           full;
  logic           empty;
  logic [31:0]    data_ext;
  logic [EW-1:0]  head;
  int             tag_int;

  assign boundary  = (timing == 32'(SLOT_CYCLES - 1));
  assign capture   = boundary && (state != IDLE);
  assign slot_next = (slot == IW'(N - 1)) ? '0 : slot + 1'b1;
  assign data_ext  = {{(32-DW){yout[DW-1]}}, yout};

  // Tag back-dates the capture to the input sample that produced it.
  always_comb begin
    tag_int = (int'(slot) + N - (LATENCY_SLOTS % N)) % N;
    tag     = IW'(tag_int);
  end

  always_comb begin
    push_req = 1'b0;
`ifdef SYSTOLIC_COLLECT_DISCARD_FILL_EN
    push_req = capture && (state == RUN);
`else
    push_req = capture;
`endif
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      timing   <= 32'(SLOT_CYCLES - 1);
      state    <= IDLE;
      slot     <= '0;
      fill_cnt <= '0;
    end else begin
      timing <= boundary ? 32'd0 : timing + 32'd1;
      if (boundary) begin
        case (state)
          IDLE: begin
            if (enable) begin
              state    <= (LATENCY_SLOTS == 0) ? RUN : FILL;
              slot     <= '0;
              fill_cnt <= '0;
            end
          end
          FILL: begin
            slot     <= slot_next;
            fill_cnt <= fill_cnt + 8'd1;
            if (!enable) begin
              state <= IDLE;
            end else if (int'(fill_cnt) + 1 >= LATENCY_SLOTS) begin
              state <= RUN;
            end
          end
          RUN: begin
            slot <= slot_next;
            if (!enable) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow <= 1'b1;
    end
  end

  systolic_result_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .clk      (clk30x),
    .rst      (rst),
    .push     (push_req),
    .push_data({data_ext, tag}),
    .pop      (res_ready),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .push_ok  (push_ok)
  );

  assign res_valid  = !empty;
  assign res_data   = head[EW-1:IW];
  assign res_index  = head[IW-1:0];
  assign frame_done = push_ok && (tag == IW'(N - 1));

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - scoreboard bench for systolic_result_collector
module tb_systolic_result_collector;
  import systolic_collect_pkg::*;

  localparam int SLOT = 30;
`ifdef SYSTOLIC_COLLECT_DISCARD_FILL_EN
  localparam bit DISCARD   = 1'b1;
  localparam int FILL_SKIP = 2;
`else
  localparam bit DISCARD   = 1'b0;
  localparam int FILL_SKIP = 0;
`endif

  logic        clk30x = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] yout;
  logic [31:0] timing;
  logic        capture;
  logic [31:0] res_data;
  logic [2:0]  res_index;
  logic        res_valid;
  logic        res_ready;
  logic        frame_done;
  logic        overflow;

  int      n_cmp = 0;
  int      n_fail = 0;
  int      pop_cnt = 0;
  result_t exp_q[$];
  int      tags [11] = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0};

  systolic_result_collector dut (
    .clk30x    (clk30x),
    .rst       (rst),
    .enable    (enable),
    .yout      (yout),
    .timing    (timing),
    .capture   (capture),
    .res_data  (res_data),
    .res_index (res_index),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  always #5 clk30x = ~clk30x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must match the scoreboard head.
  always @(negedge clk30x) begin
    if (!rst && res_valid && res_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("res_data", res_data, e.data);
        check("res_index", 32'(res_index), 32'(e.index));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk30x); #1 rst = 1'b1;
    @(posedge clk30x); #1;
    @(posedge clk30x); #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // Wait for the next slot boundary, optionally raising res_ready for that cycle only.
  task automatic boundary(input bit exp_cap, input bit exp_push, input logic [31:0] d,
                          input int tag, input bit ready_pulse);
    int n = 0;
    result_t e;
    do begin
      @(negedge clk30x);
      n++;
    end while (timing != 32'(SLOT - 2) && n < 40);
    if (n >= 40) check("boundary_timeout", 32'd1, 32'd0);
    @(posedge clk30x); #1;
    if (ready_pulse) res_ready = 1'b1;
    @(negedge clk30x);
    check("bnd_timing", timing, 32'(SLOT - 1));
    check("capture", 32'(capture), 32'(exp_cap));
    check("frame_done", 32'(frame_done), 32'(exp_push && tag == 7));
    if (exp_push) begin
      e.data  = d;
      e.index = 3'(tag);
      exp_q.push_back(e);
    end
    @(posedge clk30x); #1;
    if (ready_pulse) res_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_t;
    rst = 1'b1; enable = 1'b0; yout = '0; res_ready = 1'b0;

    // Reset values and free-running phase while idle
    do_reset();
    @(negedge clk30x);
    check("rst_timing", timing, 32'd29);
    check("rst_capture", 32'(capture), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", res_data, 32'd0);
    check("rst_index", 32'(res_index), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    exp_t = 29;
    repeat (100) begin
      @(negedge clk30x);
      exp_t = (exp_t + 1) % SLOT;
      check("idle_timing", timing, 32'(exp_t));
      check("idle_capture", 32'(capture), 32'd0);
      check("idle_valid", 32'(res_valid), 32'd0);
    end

    // Streaming with a negative sample, consumer always ready
    @(posedge clk30x); #1;
    yout = 16'hFFFE; res_ready = 1'b1; enable = 1'b1;
    boundary(1'b0, 1'b0, 32'h0, 0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      boundary(1'b1, k >= FILL_SKIP, 32'hFFFF_FFFE, tags[k], 1'b0);
      if (k == FILL_SKIP) begin
        @(negedge clk30x);
        check("first_latency_valid", 32'(res_valid), 32'd1);
        check("first_latency_index", 32'(res_index), 32'(tags[FILL_SKIP]));
      end
    end
    enable = 1'b0;
    boundary(1'b1, 1'b1, 32'hFFFF_FFFE, tags[10], 1'b0);
    boundary(1'b0, 1'b0, 32'h0, 0, 1'b0);
    check("drain_stream", 32'(exp_q.size()), 32'd0);

    // Backpressure: FIFO fills, further captures dropped
    yout = 16'h1234; res_ready = 1'b0; enable = 1'b1;
    boundary(1'b0, 1'b0, 32'h0, 0, 1'b0);
    for (int k = 0; k < 6 + FILL_SKIP; k++) begin
      boundary(1'b1, k >= FILL_SKIP && k < FILL_SKIP + 4, 32'h0000_1234, tags[k], 1'b0);
      if (k == FILL_SKIP + 3) begin
        @(negedge clk30x);
        check("held_valid", 32'(res_valid), 32'd1);
        check("held_data", res_data, 32'h0000_1234);
        check("ovf_before", 32'(overflow), 32'd0);
      end
      if (k == FILL_SKIP + 4) begin
        @(negedge clk30x);
        check("ovf_after", 32'(overflow), 32'd1);
      end
    end
    pop_cnt = 0;
    res_ready = 1'b1; enable = 1'b0;
    repeat (10) @(negedge clk30x);
    check("ovf_pops", 32'(pop_cnt), 32'd4);
    boundary(1'b1, 1'b1, 32'h0000_1234, tags[6 + FILL_SKIP], 1'b0);
    boundary(1'b0, 1'b0, 32'h0, 0, 1'b0);
    check("drain_ovf", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop exactly on the capture cycle
    do_reset();
    yout = 16'h8001; res_ready = 1'b0; enable = 1'b1;
    for (int k = 0; k < FILL_SKIP + 4; k++) begin
      boundary(1'b1, k >= FILL_SKIP, 32'hFFFF_8001, tags[k], 1'b0);
    end
    boundary(1'b1, 1'b1, 32'hFFFF_8001, tags[FILL_SKIP + 4], 1'b1);
    @(negedge clk30x);
    check("same_cycle_ovf", 32'(overflow), 32'd0);
    pop_cnt = 0;
    res_ready = 1'b1; enable = 1'b0;
    repeat (10) @(negedge clk30x);
    check("same_cycle_pops", 32'(pop_cnt), 32'd4);
    boundary(1'b1, 1'b1, 32'hFFFF_8001, tags[FILL_SKIP + 5], 1'b0);
    boundary(1'b0, 1'b0, 32'h0, 0, 1'b0);
    check("drain_same_cycle", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a slot with entries queued
    do_reset();
    yout = 16'h7FFF; res_ready = 1'b0; enable = 1'b1;
    for (int k = 0; k < FILL_SKIP + 2; k++) begin
      boundary(1'b1, k >= FILL_SKIP, 32'h0000_7FFF, tags[k], 1'b0);
    end
    @(negedge clk30x);
    check("queued_valid", 32'(res_valid), 32'd1);
    repeat (5) @(posedge clk30x);
    #1 rst = 1'b1;
    @(posedge clk30x); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk30x);
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_timing", timing, 32'd29);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_capture", 32'(capture), 32'd0);
    boundary(1'b1, !DISCARD, 32'h0000_7FFF, 6, 1'b0);
    enable = 1'b0;
    boundary(1'b1, !DISCARD, 32'h0000_7FFF, 7, 1'b0);
    boundary(1'b0, 1'b0, 32'h0, 0, 1'b0);
    res_ready = 1'b1;
    repeat (5) @(negedge clk30x);
    check("drain_restart", 32'(exp_q.size()), 32'd0);
    check("restart_empty", 32'(res_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Synthesizable receive-side companion to systolic_wrapper. Owns the per-sample slot timing and turns wrapper output into a tagged result stream.
- Generates the `timing` phase count that drives the wrapper.
- Samples `yout` once per sample slot, sign-extends it to 32 bits and tags it with the input-sample index it corresponds to.
- Buffers results in a small FIFO drained through a valid/ready port. Replaces bench-side `yout` capture in hardware and FPGA builds.

Parameters:
- N, 8: samples per frame; index tag width is IW = $clog2(N).
- SLOT_CYCLES, 30: clk30x cycles per sample slot.
- LATENCY_SLOTS, 2: wrapper latency in slots, used for index tagging.
- DEPTH, 4: result FIFO entries; must be a power of 2.
- DW, 16: width of `yout`.

Ports:
- clk30x  in  1  system clock (30x sample rate).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; start or continue capture.
- yout  in  DW  systolic_wrapper output.
- timing  out  32  slot phase, 0..SLOT_CYCLES-1, to the wrapper.
- capture  out  1  one-cycle pulse on the cycle `yout` is sampled.
- res_data  out  32  sign-extended result.
- res_index  out  IW  input-sample index of `res_data`.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accepts head.
- frame_done  out  1  one-cycle pulse when a result tagged N-1 is pushed.
- overflow  out  1  sticky; a capture was dropped because the FIFO was full.

Behaviour:
- Reset values (synchronous, rst=1 at a clk30x edge):
  - timing = SLOT_CYCLES-1, so the first post-reset cycle shows 0.
  - capture=0, res_valid=0, res_data=0, res_index=0, frame_done=0, overflow=0.
  - FIFO emptied, slot counter=0, FSM=IDLE.
- Phase counter: free-runs whenever rst=0, independent of `enable`. Increments each cycle and wraps SLOT_CYCLES-1 -> 0.
- Slot boundary: the cycle where timing==SLOT_CYCLES-1.
- FSM states: IDLE, FILL, RUN.
  - IDLE -> FILL on a slot boundary with enable=1.
  - FILL -> RUN after LATENCY_SLOTS boundaries have been counted.
  - RUN -> IDLE on a slot boundary with enable=0.
  - FILL -> IDLE on a slot boundary with enable=0.
  - `enable` is sampled only at slot boundaries; changes mid-slot have no effect.
- Capture: at each slot boundary while in FILL or RUN, `capture`=1 for that cycle.
  - Entry: {{(32-DW){yout[DW-1]}}, yout}, tag = (slot + N - LATENCY_SLOTS) mod N.
  - `slot` is the capture count since entering FILL, mod N, and increments per capture.
- Push rules:
  - Push if the FIFO is not full.
  - If full and a pop occurs the same cycle, the push is accepted; occupancy is unchanged.
  - If full with no pop, the entry is dropped and overflow is set (sticky until rst).
- Pop: on res_valid && res_ready. res_data/res_index present the head combinationally from FIFO storage. Pop while empty is ignored.
- frame_done: pulses in the push cycle of an accepted entry tagged N-1. A dropped entry generates no pulse.
- Latency: yout sampled at cycle t appears at the FIFO head at t+1 if the FIFO was empty.
- Pointers: log2(DEPTH)+1 bits each; full/empty by MSB compare.
- Reset mid-operation clears everything, including in-flight FIFO data.
- Leaving RUN keeps FIFO contents drainable.

Optional Feature:
- Macro: SYSTOLIC_COLLECT_DISCARD_FILL_EN.
- Defined: captures made in FILL are not pushed (pipeline-fill garbage discarded). `capture` still pulses and `slot` still advances, so the first pushed entry carries tag 0.
- Undefined: FILL captures are pushed like RUN captures, with tags N-2, N-1 for the defaults, matching the (8+i-2)%8 bench convention.

Decomposition:
- Package systolic_collect_pkg: FSM state enum (IDLE, FILL, RUN), SLOT_CYCLES and LATENCY_SLOTS defaults, and a result entry struct {32-bit data, IW index}.
- One sub-module: systolic_result_fifo (synchronous FIFO with push/pop/full/empty), parameterized by DEPTH and entry width.

Test Plan:
- Reset then idle with enable=0 for 100 cycles:
  - timing sequences 0..29 repeating.
  - capture never pulses; res_valid=0.
- enable=1, yout=16'hFFFE held, res_ready=1, macro undefined:
  - first result res_data=32'hFFFF_FFFE, res_index=6.
  - next result res_index=7, frame_done pulses, then index 0.
- Same stimulus with macro defined:
  - first result appears at the third boundary with res_index=0.
  - frame_done on the 10th capture.
- yout=16'h1234, res_ready=0 for 6 slots:
  - four entries held with res_data=32'h0000_1234.
  - overflow=1 after the 5th capture.
  - raising res_ready then yields exactly 4 pops.
- Full FIFO, res_ready=1 exactly in a capture cycle:
  - push accepted, occupancy stays 4, overflow stays 0.
- rst=1 mid-slot with 2 entries queued:
  - next cycle res_valid=0, timing=SLOT_CYCLES-1, overflow=0.
  - after release, FSM restarts from IDLE.
